// File: rtl/adc_current_reader_if.sv
// Signal bundle between the serial-ADC front end and its surroundings: ADC pins,
// run enable, and the published current sample with its strobes.
interface adc_current_reader_if;
    logic        enable;
    logic        adc_sdata;
    logic        adc_cs_n;
    logic        adc_sclk;
    logic [11:0] current_b_out;
    logic        sample_valid;
    logic        frame_error;

    modport master (
        input  enable,
        input  adc_sdata,
        output adc_cs_n,
        output adc_sclk,
        output current_b_out,
        output sample_valid,
        output frame_error
    );

    modport slave (
        output enable,
        output adc_sdata,
        input  adc_cs_n,
        input  adc_sclk,
        input  current_b_out,
        input  sample_valid,
        input  frame_error
    );
endinterface

// File: rtl/adc_current_reader.sv
// Periodic 16-bit SPI frame reader for a 12-bit ADC; publishes code or flags bad leading bits.
// Latency: sample_valid/frame_error one cycle after the 16th SCLK rise (t = 32*CLK_DIV+1).
// Backpressure: none; the sample stream is free-running and a consumer must take each strobe.
module adc_current_reader #(
    parameter int CLK_DIV       = 4,
    parameter int SAMPLE_PERIOD = 1000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    adc_current_reader_if.master bus
);

    generate
        if (CLK_DIV < 2 || CLK_DIV > 255) begin : g_bad_clk_div
            $error("adc_current_reader: CLK_DIV must be within 2..255");
        end
        if (SAMPLE_PERIOD < 32 * CLK_DIV + 4) begin : g_bad_period
            $error("adc_current_reader: SAMPLE_PERIOD must be >= 32*CLK_DIV+4");
        end
    endgenerate

    localparam int CW = $clog2(SAMPLE_PERIOD);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] CNT_LAST = CW'(SAMPLE_PERIOD - 1);
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
    localparam logic [5:0]    EDGES    = 6'd32;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE,
        WAIT
    } state_t;

    state_t        state, state_nxt;
    logic          enable_q;
    logic [CW-1:0] per_cnt, per_cnt_nxt;
    logic [DW-1:0] div_cnt, div_cnt_nxt;
    logic [5:0]    edge_cnt, edge_cnt_nxt;
    logic [15:0]   shreg, shreg_nxt;
    logic          cs_n, cs_n_nxt;
    logic          sclk, sclk_nxt;
    logic [11:0]   cur, cur_nxt;
    logic          sv, sv_nxt;
    logic          fe, fe_nxt;
    logic          frame_ok;
    logic          start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            enable_q <= 1'b0;
            per_cnt  <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            shreg    <= '0;
            cs_n     <= 1'b1;
            sclk     <= 1'b1;
            cur      <= '0;
            sv       <= 1'b0;
            fe       <= 1'b0;
        end else begin
            state    <= state_nxt;
            enable_q <= bus.enable;
            per_cnt  <= per_cnt_nxt;
            div_cnt  <= div_cnt_nxt;
            edge_cnt <= edge_cnt_nxt;
            shreg    <= shreg_nxt;
            cs_n     <= cs_n_nxt;
            sclk     <= sclk_nxt;
            cur      <= cur_nxt;
            sv       <= sv_nxt;
            fe       <= fe_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        per_cnt_nxt  = (state == IDLE) ? per_cnt : per_cnt + CW'(1);
        div_cnt_nxt  = div_cnt;
        edge_cnt_nxt = edge_cnt;
        shreg_nxt    = shreg;
        cs_n_nxt     = 1'b1;
        sclk_nxt     = sclk;
        cur_nxt      = cur;
        sv_nxt       = 1'b0;
        fe_nxt       = 1'b0;
        frame_ok     = (shreg[15:12] == 4'd0);
        start        = 1'b0;

        case (state)
            IDLE: begin
                if (enable_q) begin
                    start = 1'b1;
                end
            end
            SHIFT: begin
                cs_n_nxt = 1'b0;
                if (edge_cnt == EDGES) begin
                    // All 16 bits are in; the outputs change together with the DONE state.
                    state_nxt = DONE;
                    cs_n_nxt  = 1'b1;
                    if (frame_ok) begin
                        cur_nxt = shreg[11:0];
                        sv_nxt  = 1'b1;
                    end else begin
                        fe_nxt = 1'b1;
                    end
                end else if (div_cnt == DIV_LAST) begin
                    div_cnt_nxt  = '0;
                    edge_cnt_nxt = edge_cnt + 6'd1;
                    sclk_nxt     = ~sclk;
                    if (!sclk) begin
                        shreg_nxt = {shreg[14:0], bus.adc_sdata};
                    end
                end else begin
                    div_cnt_nxt = div_cnt + DW'(1);
                end
            end
            DONE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                if (per_cnt == CNT_LAST) begin
                    if (enable_q) begin
                        start = 1'b1;
                    end else begin
                        state_nxt   = IDLE;
                        per_cnt_nxt = '0;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        if (start) begin
            state_nxt    = SHIFT;
            cs_n_nxt     = 1'b0;
            sclk_nxt     = 1'b1;
            per_cnt_nxt  = '0;
            div_cnt_nxt  = '0;
            edge_cnt_nxt = '0;
            shreg_nxt    = '0;
        end
    end

    assign bus.adc_cs_n      = cs_n;
    assign bus.adc_sclk      = sclk;
    assign bus.current_b_out = cur;
    assign bus.sample_valid  = sv;
    assign bus.frame_error   = fe;

endmodule

// File: tb/tb_adc_current_reader.sv
// Scoreboarded bench: two instances (CLK_DIV=4/1000 and the CLK_DIV=2/68 minimum period),
// each with an ADC frame model, directed frames and a pulse monitor.
module tb_adc_current_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n_a, rst_n_b;
    adc_current_reader_if bus_a ();
    adc_current_reader_if bus_b ();

    adc_current_reader #(.CLK_DIV(4), .SAMPLE_PERIOD(1000)) dut_a (
        .clk(clk), .rst_n(rst_n_a), .bus(bus_a.master));
    adc_current_reader #(.CLK_DIV(2), .SAMPLE_PERIOD(68)) dut_b (
        .clk(clk), .rst_n(rst_n_b), .bus(bus_b.master));

    localparam int DONE_T_A = 32 * 4 + 1;
    localparam int DONE_T_B = 32 * 2 + 1;

    typedef struct {
        logic        is_err;
        logic [11:0] val;
    } exp_t;

    typedef struct {
        logic [15:0] frame;
        int          gap;
        logic        full;
    } frm_t;

    exp_t   sb_a[$], sb_b[$];
    frm_t   fq_a[$], fq_b[$];
    int     total = 0;
    int     bad = 0;
    longint cyc = 0;
    int     t_a = 0, t_b = 0, nfall_a = 0, nfall_b = 0;
    logic   cs_prev_a = 1'b1, cs_prev_b = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string nm, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
        end
    endfunction

    task automatic push_a(logic [15:0] f, int gap, logic full, logic has_exp, logic is_err, logic [11:0] v);
        fq_a.push_back('{f, gap, full});
        if (has_exp) sb_a.push_back('{is_err, v});
    endtask

    task automatic push_b(logic [15:0] f, int gap, logic is_err, logic [11:0] v);
        fq_b.push_back('{f, gap, 1'b1});
        sb_b.push_back('{is_err, v});
    endtask

    // ADC model A: first bit appears on the first SCLK fall, later bits on each fall.
    logic       sdata_a = 1'b0;
    frm_t       cur_a = '{16'h0, 0, 1'b0};
    int         idx_a = 0, rise_a = 0;
    longint     last_fall_a = 0;
    assign bus_a.adc_sdata = sdata_a;

    always @(negedge bus_a.adc_cs_n or negedge bus_a.adc_sclk) begin
        if (!bus_a.adc_cs_n && bus_a.adc_sclk) begin
            if (fq_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_frame_underrun: unexpected CS fall at cycle %0d", cyc);
                cur_a = '{16'h0, 0, 1'b0};
            end else begin
                cur_a = fq_a.pop_front();
                if (cur_a.gap != 0) check("a_cs_period", cyc - last_fall_a, cur_a.gap);
            end
            last_fall_a = cyc;
            idx_a = 0;
        end else if (!bus_a.adc_cs_n && !bus_a.adc_sclk && idx_a < 16) begin
            sdata_a = cur_a.frame[15-idx_a];
            idx_a++;
        end
    end

    always @(posedge bus_a.adc_sclk or posedge bus_a.adc_cs_n) begin
        if (bus_a.adc_cs_n) begin
            if (cur_a.full) check("a_sclk_rises", rise_a, 16);
            rise_a = 0;
        end else begin
            rise_a++;
        end
    end

    // ADC model B
    logic       sdata_b = 1'b0;
    frm_t       cur_b = '{16'h0, 0, 1'b0};
    int         idx_b = 0, rise_b = 0;
    longint     last_fall_b = 0;
    assign bus_b.adc_sdata = sdata_b;

    always @(negedge bus_b.adc_cs_n or negedge bus_b.adc_sclk) begin
        if (!bus_b.adc_cs_n && bus_b.adc_sclk) begin
            if (fq_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_frame_underrun: unexpected CS fall at cycle %0d", cyc);
                cur_b = '{16'h0, 0, 1'b0};
            end else begin
                cur_b = fq_b.pop_front();
                if (cur_b.gap != 0) check("b_cs_period", cyc - last_fall_b, cur_b.gap);
            end
            last_fall_b = cyc;
            idx_b = 0;
        end else if (!bus_b.adc_cs_n && !bus_b.adc_sclk && idx_b < 16) begin
            sdata_b = cur_b.frame[15-idx_b];
            idx_b++;
        end
    end

    always @(posedge bus_b.adc_sclk or posedge bus_b.adc_cs_n) begin
        if (bus_b.adc_cs_n) begin
            if (cur_b.full) check("b_sclk_rises", rise_b, 16);
            rise_b = 0;
        end else begin
            rise_b++;
        end
    end

    // Pulse monitors: pop the expected result whenever a strobe appears.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (cs_prev_a && !bus_a.adc_cs_n) begin t_a = 0; nfall_a++; end
        else t_a++;
        cs_prev_a = bus_a.adc_cs_n;
        if (bus_a.sample_valid || bus_a.frame_error) begin
            check("a_pulse_excl", bus_a.sample_valid & bus_a.frame_error, 0);
            if (sb_a.size() == 0) begin
                total++; bad++;
                $display("FAIL a_unexpected_pulse: sv=%0b fe=%0b at t=%0d", bus_a.sample_valid, bus_a.frame_error, t_a);
            end else begin
                e = sb_a.pop_front();
                check("a_kind", bus_a.frame_error, e.is_err);
                check("a_value", bus_a.current_b_out, e.val);
                check("a_time", t_a, DONE_T_A);
                check("a_cs_high", bus_a.adc_cs_n, 1);
            end
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (cs_prev_b && !bus_b.adc_cs_n) begin t_b = 0; nfall_b++; end
        else t_b++;
        cs_prev_b = bus_b.adc_cs_n;
        if (bus_b.sample_valid || bus_b.frame_error) begin
            check("b_pulse_excl", bus_b.sample_valid & bus_b.frame_error, 0);
            if (sb_b.size() == 0) begin
                total++; bad++;
                $display("FAIL b_unexpected_pulse: sv=%0b fe=%0b at t=%0d", bus_b.sample_valid, bus_b.frame_error, t_b);
            end else begin
                e = sb_b.pop_front();
                check("b_kind", bus_b.frame_error, e.is_err);
                check("b_value", bus_b.current_b_out, e.val);
                check("b_time", t_b, DONE_T_B);
                check("b_cs_high", bus_b.adc_cs_n, 1);
            end
        end
    end

    task automatic wait_fall_a(int target, int lim, string nm);
        int n = 0;
        while (nfall_a < target && n < lim) begin
            @(posedge clk); #2;
            n++;
        end
        check(nm, nfall_a, target);
    endtask

    task automatic wait_fall_b(int target, int lim, string nm);
        int n = 0;
        while (nfall_b < target && n < lim) begin
            @(posedge clk); #2;
            n++;
        end
        check(nm, nfall_b, target);
    endtask

    // Enable is taken at edge e; chip select must fall at edge e+1.
    task automatic start_a(string nm);
        @(negedge clk) bus_a.enable = 1'b1;
        @(posedge clk); #2;
        check({nm, "_edge_e"}, bus_a.adc_cs_n, 1);
        @(posedge clk); #2;
        check({nm, "_edge_e1"}, bus_a.adc_cs_n, 0);
    endtask

    initial begin
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b0;
        rst_n_a = 1'b0;
        rst_n_b = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check("rst_cs_n", bus_a.adc_cs_n, 1);
        check("rst_sclk", bus_a.adc_sclk, 1);
        check("rst_current", bus_a.current_b_out, 0);
        check("rst_valid", bus_a.sample_valid, 0);
        check("rst_error", bus_a.frame_error, 0);
        check("rst_b_cs_n", bus_b.adc_cs_n, 1);
        @(negedge clk);
        rst_n_a = 1'b1;
        rst_n_b = 1'b1;
        repeat (2) @(posedge clk);

        // Run A continuously, bad frame in the middle, enable dropped mid-frame on the last.
        push_a(16'h0FFF, 0,    1'b1, 1'b1, 1'b0, 12'hFFF);
        push_a(16'h0000, 1000, 1'b1, 1'b1, 1'b0, 12'h000);
        push_a(16'h09C4, 1000, 1'b1, 1'b1, 1'b0, 12'h9C4);
        push_a(16'h4123, 1000, 1'b1, 1'b1, 1'b1, 12'h9C4);
        push_a(16'h0ABC, 1000, 1'b1, 1'b1, 1'b0, 12'hABC);
        start_a("a_start1");
        wait_fall_a(5, 5000, "a_reach_frame5");
        repeat (60) @(posedge clk);
        @(negedge clk) bus_a.enable = 1'b0;
        repeat (1300) @(posedge clk);
        #2;
        check("a_stays_idle", nfall_a, 5);
        check("a_idle_cs_n", bus_a.adc_cs_n, 1);

        // Restart from IDLE, then reset in the middle of the following frame.
        push_a(16'h0123, 0,    1'b1, 1'b1, 1'b0, 12'h123);
        push_a(16'h0555, 1000, 1'b0, 1'b0, 1'b0, 12'h000);
        start_a("a_start2");
        wait_fall_a(7, 1500, "a_reach_frame7");
        repeat (60) @(posedge clk);
        #2 rst_n_a = 1'b0;
        #1;
        check("midrst_cs_n", bus_a.adc_cs_n, 1);
        check("midrst_sclk", bus_a.adc_sclk, 1);
        check("midrst_current", bus_a.current_b_out, 0);
        check("midrst_valid", bus_a.sample_valid, 0);
        push_a(16'h0777, 0, 1'b1, 1'b1, 1'b0, 12'h777);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n_a = 1'b1;
        @(posedge clk); #2;
        check("a_start3_edge_e", bus_a.adc_cs_n, 1);
        @(posedge clk); #2;
        check("a_start3_edge_e1", bus_a.adc_cs_n, 0);
        @(negedge clk) bus_a.enable = 1'b0;
        repeat (1200) @(posedge clk);
        #2;
        check("a_after_reset_frames", nfall_a, 8);

        // Minimum period on B: back-to-back frames, all published.
        push_b(16'h0001, 0,  1'b0, 12'h001);
        push_b(16'h0FFE, 68, 1'b0, 12'hFFE);
        push_b(16'h8000, 68, 1'b1, 12'hFFE);
        push_b(16'h0800, 68, 1'b0, 12'h800);
        push_b(16'h0555, 68, 1'b0, 12'h555);
        push_b(16'h0AAA, 68, 1'b0, 12'hAAA);
        @(negedge clk) bus_b.enable = 1'b1;
        wait_fall_b(6, 600, "b_reach_frame6");
        @(negedge clk) bus_b.enable = 1'b0;
        repeat (150) @(posedge clk);
        #2;
        check("b_stops", nfall_b, 6);

        check("a_sb_drained", sb_a.size(), 0);
        check("a_frames_used", fq_a.size(), 0);
        check("b_sb_drained", sb_b.size(), 0);
        check("b_frames_used", fq_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
